// File: rtl/stream_mux.sv
// ============================================================================
// Module   : stream_mux
// Brief    : N-channel packet multiplexer with valid/ready handshakes.
//            Grants one input channel per packet (first beat to `last` beat)
//            and forwards beats through a single output register stage.
// Config   : STREAM_MUX_RR_EN defined   -> round-robin arbitration
//            STREAM_MUX_RR_EN undefined -> fixed priority (lowest index wins)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [CW-1:0]             out_chan
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [CW-1:0]     lock_ch_q,   lock_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [CW-1:0]     out_chan_q,  out_chan_d;
`ifdef STREAM_MUX_RR_EN
    logic [CW-1:0]     rr_ptr_q,    rr_ptr_d;
`endif

    logic              win_found;
    logic [CW-1:0]     win_ch;
    logic              grant_exists;
    logic [CW-1:0]     grant_ch;
    logic              can_load;
    logic              xfer;
    logic [WIDTH-1:0]  grant_data;
    logic              grant_last;

    // Arbitration among valid channels; only consulted while IDLE.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
`ifdef STREAM_MUX_RR_EN
        for (int k = 0; k < CHANNELS; k++) begin
            logic [CW-1:0] idx;
            idx = CW'((int'(rr_ptr_q) + k) % CHANNELS);
            if (!win_found && in_valid[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
`else
        for (int k = 0; k < CHANNELS; k++) begin
            if (!win_found && in_valid[CW'(k)]) begin
                win_found = 1'b1;
                win_ch    = CW'(k);
            end
        end
`endif
    end

    // Grant selection, handshake and next-state logic.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        in_ready    = '0;
`ifdef STREAM_MUX_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        if (state_q == S_LOCKED) begin
            grant_exists = 1'b1;
            grant_ch     = lock_ch_q;
        end else begin
            grant_exists = win_found;
            grant_ch     = win_ch;
        end

        can_load   = !out_valid_q || out_ready;
        grant_data = in_data[grant_ch*WIDTH +: WIDTH];
        grant_last = in_last[grant_ch];

        // rst_n gating keeps in_ready low during an asynchronous reset.
        if (grant_exists && can_load && rst_n) begin
            in_ready[grant_ch] = 1'b1;
        end
        xfer = grant_exists && can_load && in_valid[grant_ch];

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_last_d  = grant_last;
            out_chan_d  = grant_ch;
            if (state_q == S_IDLE && !grant_last) begin
                state_d   = S_LOCKED;
                lock_ch_d = grant_ch;
            end else if (state_q == S_LOCKED && grant_last) begin
                state_d   = S_IDLE;
            end
`ifdef STREAM_MUX_RR_EN
            if (grant_last) begin
                rr_ptr_d = CW'((int'(grant_ch) + 1) % CHANNELS);
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, lock and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lock_ch_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// Module   : tb_stream_mux
// Brief    : Directed table-driven bench for stream_mux (WIDTH=8, CHANNELS=4).
//            Arbitration expectations follow STREAM_MUX_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_chan;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic        exp_ol;
        logic [1:0]  exp_oc;
    } vec_t;

    vec_t tbl[18];

    stream_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                                logic o, logic [3:0] er, logic eov, logic [7:0] eod,
                                logic eol, logic [1:0] eoc);
        vec_t t;
        t.rst_n = r;   t.valid = v;   t.data = d;     t.last = l;   t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ol = eol; t.exp_oc = eoc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, check in_ready before the rising edge and
    // the registered outputs just after it.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        rst_n     = v.rst_n;
        in_valid  = v.valid;
        in_data   = v.data;
        in_last   = v.last;
        out_ready = v.ordy;
        n_vec++;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        chk({tag, " out_data"},  32'(out_data),  32'(v.exp_od));
        chk({tag, " out_last"},  32'(out_last),  32'(v.exp_ol));
        chk({tag, " out_chan"},  32'(out_chan),  32'(v.exp_oc));
    endtask

    initial begin
        // Single beat from ch2.
        tbl[0]  = mk(1, 4'b0100, 32'h00A50000, 4'b0100, 1, 4'b0100, 1, 8'hA5, 1, 2);
        // ch1 packet 11/12/13 while ch0 keeps offering a beat.
        tbl[1]  = mk(1, 4'b0010, 32'h00001100, 4'b0000, 1, 4'b0010, 1, 8'h11, 0, 1);
        tbl[2]  = mk(1, 4'b0011, 32'h00001201, 4'b0001, 1, 4'b0010, 1, 8'h12, 0, 1);
        tbl[3]  = mk(1, 4'b0011, 32'h00001301, 4'b0011, 1, 4'b0010, 1, 8'h13, 1, 1);
        tbl[4]  = mk(1, 4'b0001, 32'h00000001, 4'b0001, 1, 4'b0001, 1, 8'h01, 1, 0);
        // ch2 packet 21/22/23 with three stalled cycles.
        tbl[5]  = mk(1, 4'b0100, 32'h00210000, 4'b0000, 1, 4'b0100, 1, 8'h21, 0, 2);
        tbl[6]  = mk(1, 4'b0100, 32'h00220000, 4'b0000, 0, 4'b0000, 1, 8'h21, 0, 2);
        tbl[7]  = mk(1, 4'b0100, 32'h00220000, 4'b0000, 0, 4'b0000, 1, 8'h21, 0, 2);
        tbl[8]  = mk(1, 4'b0100, 32'h00220000, 4'b0000, 0, 4'b0000, 1, 8'h21, 0, 2);
        tbl[9]  = mk(1, 4'b0100, 32'h00220000, 4'b0000, 1, 4'b0100, 1, 8'h22, 0, 2);
        tbl[10] = mk(1, 4'b0100, 32'h00230000, 4'b0100, 1, 4'b0100, 1, 8'h23, 1, 2);
        // Drain: valid drops, payload holds.
        tbl[11] = mk(1, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h23, 1, 2);
        // Reset cycle to bring the round-robin pointer back to 0.
        tbl[12] = mk(0, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        // All channels send single-beat packets.
`ifdef STREAM_MUX_RR_EN
        tbl[13] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0001, 1, 8'h50, 1, 0);
        tbl[14] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0010, 1, 8'h51, 1, 1);
        tbl[15] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0100, 1, 8'h52, 1, 2);
        tbl[16] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b1000, 1, 8'h53, 1, 3);
        tbl[17] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0001, 1, 8'h50, 1, 0);
`else
        for (int i = 13; i < 18; i++)
            tbl[i] = mk(1, 4'b1111, 32'h53525150, 4'b1111, 1, 4'b0001, 1, 8'h50, 1, 0);
`endif

        // Reset held with every channel valid.
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'hFFFFFFFF;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        #12;
        n_vec++;
        chk("reset in_ready",  32'(in_ready),  32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data",  32'(out_data),  32'h0);
        chk("reset out_last",  32'(out_last),  32'h0);
        chk("reset out_chan",  32'(out_chan),  32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        for (int i = 0; i < 18; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Mid-packet reset: two beats of a ch3 packet, then reset.
        apply("mid b1", mk(1, 4'b1000, 32'h31000000, 4'b0000, 1, 4'b1000, 1, 8'h31, 0, 3));
        apply("mid b2", mk(1, 4'b1000, 32'h32000000, 4'b0000, 1, 4'b1000, 1, 8'h32, 0, 3));
        @(negedge clk);
        rst_n   = 1'b0;
        in_data = 32'h33000000;
        n_vec++;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'h0);
        chk("mid rst out_data",  32'(out_data),  32'h0);
        chk("mid rst out_chan",  32'(out_chan),  32'h0);
        chk("mid rst in_ready",  32'(in_ready),  32'h0);
        // Lock must be gone: ch0 wins although ch3 is still offering.
        apply("post rst", mk(1, 4'b1001, 32'h3300000A, 4'b0001, 1, 4'b0001, 1, 8'h0A, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
